wptr_handler_lvl: RTL and testbench

Parametrised write-domain pointer handler for the asynchronous FIFO. It keeps the binary and Gray write pointers and a registered full flag. It also provides:
- write-address output
- registered fill level
- programmable almost-full flag
- sticky overflow error with clear

It sits in the write clock domain. It feeds g_wptr to the read-side synchroniser and w_addr/w_accept to the dual-port memory. It consumes the 2-flop-synchronised Gray read pointer.

---
 rtl/wptr_handler_lvl_if.sv | 32 +++
 rtl/wptr_handler_lvl.sv | 74 +++++++
 tb/tb_wptr_handler_lvl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wptr_handler_lvl_if.sv
// Write-side pointer handler bus: request/threshold/clear inputs in,
// pointers, memory strobe and status flags out.
interface wptr_handler_lvl_if #(
    parameter int ADDR_WIDTH = 3
);
    localparam int PTR_WIDTH = ADDR_WIDTH + 1;

    logic                  w_en;
    logic [PTR_WIDTH-1:0]  g_rptr_sync;
    logic [PTR_WIDTH-1:0]  af_thresh;
    logic                  ovf_clr;
    logic [PTR_WIDTH-1:0]  b_wptr;
    logic [PTR_WIDTH-1:0]  g_wptr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_accept;
    logic                  full;
    logic                  almost_full;
    logic [PTR_WIDTH-1:0]  wr_level;
    logic                  overflow;

    modport master (
        output w_en, g_rptr_sync, af_thresh, ovf_clr,
        input  b_wptr, g_wptr, w_addr, w_accept,
        input  full, almost_full, wr_level, overflow
    );

    modport slave (
        input  w_en, g_rptr_sync, af_thresh, ovf_clr,
        output b_wptr, g_wptr, w_addr, w_accept,
        output full, almost_full, wr_level, overflow
    );
endinterface

// File: rtl/wptr_handler_lvl.sv
// Async FIFO write-domain pointer handler: binary/Gray write pointers,
// full, fill level, almost-full and sticky overflow.
// Ports: w_clk, w_rst_n (async active-low), bus (wptr_handler_lvl_if.slave).
module wptr_handler_lvl #(
    parameter int ADDR_WIDTH = 3
) (
    input logic                 w_clk,
    input logic                 w_rst_n,
    wptr_handler_lvl_if.slave   bus
);
    localparam int PTR_WIDTH = ADDR_WIDTH + 1;

    logic [PTR_WIDTH-1:0] r_b_wptr;
    logic [PTR_WIDTH-1:0] r_g_wptr;
    logic                 r_full;
    logic                 r_almost_full;
    logic [PTR_WIDTH-1:0] r_wr_level;
    logic                 r_overflow;

    logic                 w_accept;
    logic [PTR_WIDTH-1:0] w_b_next;
    logic [PTR_WIDTH-1:0] w_g_next;
    logic [PTR_WIDTH-1:0] w_b_rptr;
    logic [PTR_WIDTH-1:0] w_lvl_next;
    logic [PTR_WIDTH-1:0] w_g_full;

    assign w_accept = bus.w_en & ~r_full;
    assign w_b_next = r_b_wptr + PTR_WIDTH'(w_accept);
    assign w_g_next = w_b_next ^ (w_b_next >> 1);

    // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        w_b_rptr = '0;
        for (int i = 0; i < PTR_WIDTH; i++) begin
            w_b_rptr[i] = ^(bus.g_rptr_sync >> i);
        end
    end

    assign w_lvl_next = w_b_next - w_b_rptr;

    // Full when the write pointer is one lap ahead: in Gray code that is
    // the read pointer with its top two bits inverted.
    assign w_g_full = {~bus.g_rptr_sync[PTR_WIDTH-1:PTR_WIDTH-2],
                       bus.g_rptr_sync[PTR_WIDTH-3:0]};

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_b_wptr      <= '0;
            r_g_wptr      <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_wr_level    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_b_wptr      <= w_b_next;
            r_g_wptr      <= w_g_next;
            r_full        <= (w_g_next == w_g_full);
            r_wr_level    <= w_lvl_next;
            r_almost_full <= (w_lvl_next >= bus.af_thresh);
            // A blocked write sets the flag even if clear is asserted.
            r_overflow    <= (bus.w_en & r_full)
                           | (r_overflow & ~bus.ovf_clr);
        end
    end

    assign bus.b_wptr      = r_b_wptr;
    assign bus.g_wptr      = r_g_wptr;
    assign bus.w_addr      = r_b_wptr[ADDR_WIDTH-1:0];
    assign bus.w_accept    = w_accept;
    assign bus.full        = r_full;
    assign bus.almost_full = r_almost_full;
    assign bus.wr_level    = r_wr_level;
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_wptr_handler_lvl.sv
// Directed testbench for wptr_handler_lvl (ADDR_WIDTH=3).
// Drives through the interface master view; checks with immediate asserts.
module tb_wptr_handler_lvl;
    logic w_clk;
    logic w_rst_n;
    int   nvec;
    int   nerr;
    logic [3:0] prev_g;
    logic [3:0] exp_b;

    wptr_handler_lvl_if #(.ADDR_WIDTH(3)) bus ();

    wptr_handler_lvl #(.ADDR_WIDTH(3)) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .bus     (bus)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs settle, inputs may change.
    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".b"},   16'(bus.b_wptr), 16'h0);
        chk({tag, ".g"},   16'(bus.g_wptr), 16'h0);
        chk({tag, ".f"},   16'(bus.full), 16'h0);
        chk({tag, ".af"},  16'(bus.almost_full), 16'h0);
        chk({tag, ".lvl"}, 16'(bus.wr_level), 16'h0);
        chk({tag, ".ovf"}, 16'(bus.overflow), 16'h0);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        w_rst_n = 1'b0;
        bus.w_en = 1'b0;
        bus.g_rptr_sync = 4'b0000;
        bus.af_thresh = 4'd6;
        bus.ovf_clr = 1'b0;
        #2;
        chk_zero("rst");
        step();
        w_rst_n = 1'b1;

        // Fill 8 words with reader at 0.
        bus.w_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("fill%0d.b", i), 16'(bus.b_wptr), 16'(i));
            chk($sformatf("fill%0d.lvl", i), 16'(bus.wr_level), 16'(i));
            chk($sformatf("fill%0d.af", i), 16'(bus.almost_full),
                16'(i >= 6));
            chk($sformatf("fill%0d.f", i), 16'(bus.full), 16'(i == 8));
        end
        chk("fill.g", 16'(bus.g_wptr), 16'b1100);
        chk("fill.addr", 16'(bus.w_addr), 16'h0);
        chk("fill.acc", 16'(bus.w_accept), 16'h0);
        chk("fill.ovf", 16'(bus.overflow), 16'h0);

        // Blocked writes.
        step();
        chk("blk1.b", 16'(bus.b_wptr), 16'd8);
        chk("blk1.ovf", 16'(bus.overflow), 16'h1);
        step();
        chk("blk2.b", 16'(bus.b_wptr), 16'd8);
        chk("blk2.ovf", 16'(bus.overflow), 16'h1);
        bus.w_en = 1'b0;
        bus.ovf_clr = 1'b1;
        step();
        chk("clr.ovf", 16'(bus.overflow), 16'h0);
        bus.w_en = 1'b1;
        step();
        chk("setdom1.ovf", 16'(bus.overflow), 16'h1);
        step();
        chk("setdom2.ovf", 16'(bus.overflow), 16'h1);
        chk("setdom.b", 16'(bus.b_wptr), 16'd8);
        bus.w_en = 1'b0;
        bus.ovf_clr = 1'b0;

        // Reader advances.
        bus.g_rptr_sync = 4'b0001;
        step();
        chk("rd1.f", 16'(bus.full), 16'h0);
        chk("rd1.lvl", 16'(bus.wr_level), 16'd7);
        chk("rd1.af", 16'(bus.almost_full), 16'h1);
        bus.g_rptr_sync = 4'b0111;
        step();
        chk("rd5.lvl", 16'(bus.wr_level), 16'd3);
        chk("rd5.af", 16'(bus.almost_full), 16'h0);

        // Wrap: reader at 8, writer 8 -> 16 (0).
        bus.g_rptr_sync = 4'b1100;
        bus.w_en = 1'b1;
        prev_g = bus.g_wptr;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_b = 4'(8 + i);
            chk($sformatf("wrap%0d.b", i), 16'(bus.b_wptr), 16'(exp_b));
            chk($sformatf("wrap%0d.g", i), 16'(bus.g_wptr),
                16'(exp_b ^ (exp_b >> 1)));
            chk($sformatf("wrap%0d.1bit", i),
                16'($countones(bus.g_wptr ^ prev_g)), 16'd1);
            prev_g = bus.g_wptr;
        end
        chk("wrap.f", 16'(bus.full), 16'h1);
        chk("wrap.lvl", 16'(bus.wr_level), 16'd8);

        // Simultaneous write and read at level 4.
        bus.w_en = 1'b0;
        bus.g_rptr_sync = 4'b1010;
        step();
        chk("sim0.lvl", 16'(bus.wr_level), 16'd4);
        chk("sim0.f", 16'(bus.full), 16'h0);
        bus.g_rptr_sync = 4'b1011;
        bus.w_en = 1'b1;
        step();
        chk("sim.lvl", 16'(bus.wr_level), 16'd4);
        chk("sim.b", 16'(bus.b_wptr), 16'd1);
        chk("sim.f", 16'(bus.full), 16'h0);

        // Async reset mid-fill.
        bus.g_rptr_sync = 4'b0000;
        for (int i = 0; i < 5; i++) step();
        chk("pre.b", 16'(bus.b_wptr), 16'd6);
        #2;
        w_rst_n = 1'b0;
        #1;
        chk_zero("arst");
        bus.w_en = 1'b0;
        bus.af_thresh = 4'd0;
        step();
        w_rst_n = 1'b1;
        step();
        chk("af0.af", 16'(bus.almost_full), 16'h1);
        chk("af0.b", 16'(bus.b_wptr), 16'd0);
        bus.w_en = 1'b1;
        step();
        chk("rel.b", 16'(bus.b_wptr), 16'd1);
        chk("rel.lvl", 16'(bus.wr_level), 16'd1);

        // Threshold above depth never asserts.
        bus.af_thresh = 4'd9;
        for (int i = 0; i < 7; i++) step();
        chk("af9.lvl", 16'(bus.wr_level), 16'd8);
        chk("af9.f", 16'(bus.full), 16'h1);
        chk("af9.af", 16'(bus.almost_full), 16'h0);
        bus.w_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
